// File: rtl/gsensor_spi_sampler.sv
// gsensor_spi_sampler: SPI mode-3 master that configures the ADXL345, then burst-reads X/Y/Z.
// Latency: accel_x/y/z and sample_valid update one clk after cs_n rises at the end of the read frame.
// Backpressure: none. Samples are not queued; a trigger that arrives mid-transaction starts the next read after the gap.
// Build option GSENSOR_DRDY_EN: adds the INT_ENABLE write and triggers reads from synchronised INT1 instead of the period timer.
module gsensor_spi_sampler #(
  parameter int CLK_DIV       = 13,
  parameter int SAMPLE_PERIOD = 500000,
  parameter int CS_GAP        = 50,
  parameter int PWRUP_WAIT    = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        gsensor_int1,
  input  logic        spi_sdo,
  output logic        spi_sdi,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] ST_PWRUP = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_IDLE  = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;
  localparam logic [2:0] ST_LATCH = 3'd5;

  localparam logic [7:0] RD_CMD    = 8'hF2;   // read, multi-byte, start at DATAX0 (0x32)
  localparam logic [5:0] INIT_BITS = 6'd16;
  localparam logic [5:0] READ_BITS = 6'd56;

`ifdef GSENSOR_DRDY_EN
  localparam int NUM_INIT = 4;
`else
  localparam int NUM_INIT = 3;
`endif

  // Register writes issued after power-up, one CS frame each.
  function automatic logic [15:0] init_word(input logic [1:0] idx);
    case (idx)
      2'd0:    init_word = 16'h310B;  // DATA_FORMAT: full resolution, +/-16 g
      2'd1:    init_word = 16'h2C0A;  // BW_RATE: 100 Hz
      2'd2:    init_word = 16'h2D08;  // POWER_CTL: measure
      default: init_word = 16'h2E80;  // INT_ENABLE: DATA_READY (only reached with DRDY build)
    endcase
  endfunction

  logic [2:0]       state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;          // power-up wait and CS gap counter
  logic [DIV_W-1:0] div_q, div_d;          // clk cycles within an SCLK half-period
  logic [6:0]       half_q, half_d;        // SCLK edge index within the frame
  logic [5:0]       nbits_q, nbits_d;      // frame length in bits
  logic [55:0]      tx_q, tx_d;            // MOSI shifter, MSB goes out first
  logic [47:0]      rx_q, rx_d;            // MISO shifter, keeps the last 6 bytes
  logic [1:0]       init_idx_q, init_idx_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             sdi_q, sdi_d;
  logic [15:0]      accel_x_q, accel_x_d;
  logic [15:0]      accel_y_q, accel_y_d;
  logic [15:0]      accel_z_q, accel_z_d;
  logic             sample_valid_q, sample_valid_d;
  logic             init_done_q, init_done_d;
  logic             busy_q, busy_d;

  logic             read_trig;
  logic             read_go;
  logic             load_frame;
  logic [55:0]      load_word;
  logic [5:0]       load_bits;

`ifdef GSENSOR_DRDY_EN
  logic int1_meta_q, int1_meta_d;
  logic int1_sync_q, int1_sync_d;

  // Two-flop synchroniser for the asynchronous INT1 pin.
  always_comb begin
    int1_meta_d = gsensor_int1;
    int1_sync_d = int1_meta_q;
  end

  // Synchroniser state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int1_meta_q <= 1'b0;
      int1_sync_q <= 1'b0;
    end else begin
      int1_meta_q <= int1_meta_d;
      int1_sync_q <= int1_sync_d;
    end
  end

  assign read_trig = int1_sync_q;
`else
  localparam int TMR_W = $clog2(SAMPLE_PERIOD + 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             unused_int1;

  assign unused_int1 = gsensor_int1;

  // Period timer: reloads on each read start, then counts down and parks at zero (expired).
  always_comb begin
    tmr_d = tmr_q;
    if (read_go) begin
      tmr_d = TMR_W'(SAMPLE_PERIOD - 1);
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - TMR_W'(1);
    end
  end

  // Timer state; starts expired so the first read follows init immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign read_trig = (tmr_q == '0);
`endif

  assign read_go = (state_q == ST_IDLE) && en && read_trig;

  // Sequencer plus bit engine: walks power-up, config frames, gaps and read frames.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    div_d          = div_q;
    half_d         = half_q;
    nbits_d        = nbits_q;
    tx_d           = tx_q;
    rx_d           = rx_q;
    init_idx_d     = init_idx_q;
    cs_n_d         = cs_n_q;
    sclk_d         = sclk_q;
    sdi_d          = sdi_q;
    accel_x_d      = accel_x_q;
    accel_y_d      = accel_y_q;
    accel_z_d      = accel_z_q;
    sample_valid_d = 1'b0;
    init_done_d    = init_done_q;
    load_frame     = 1'b0;
    load_word      = '0;
    load_bits      = INIT_BITS;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == 32'(PWRUP_WAIT - 1)) begin
          state_d    = ST_INIT;
          init_idx_d = 2'd0;
          load_frame = 1'b1;
          load_word  = {init_word(2'd0), 40'd0};
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_INIT, ST_READ: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (half_q == {nbits_q, 1'b0}) begin
            // One half-period after the last rising edge: close the frame.
            cs_n_d  = 1'b1;
            sdi_d   = 1'b0;
            cnt_d   = '0;
            state_d = (state_q == ST_READ) ? ST_LATCH : ST_GAP;
          end else if (!half_q[0]) begin
            sclk_d = 1'b0;
            sdi_d  = tx_q[55];
            tx_d   = {tx_q[54:0], 1'b0};
            half_d = half_q + 7'd1;
          end else begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[46:0], spi_sdo};
            half_d = half_q + 7'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_LATCH: begin
        // Bytes arrive X0,X1,Y0,Y1,Z0,Z1; each axis is little-endian.
        accel_x_d      = {rx_q[39:32], rx_q[47:40]};
        accel_y_d      = {rx_q[23:16], rx_q[31:24]};
        accel_z_d      = {rx_q[7:0],   rx_q[15:8]};
        sample_valid_d = 1'b1;
        state_d        = ST_GAP;
      end

      ST_GAP: begin
        if (cnt_q == 32'(CS_GAP - 1)) begin
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (init_idx_q == 2'(NUM_INIT - 1)) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            state_d    = ST_INIT;
            load_frame = 1'b1;
            load_word  = {init_word(init_idx_q + 2'd1), 40'd0};
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_IDLE: begin
        if (read_go) begin
          state_d    = ST_READ;
          load_frame = 1'b1;
          load_word  = {RD_CMD, 48'd0};
          load_bits  = READ_BITS;
        end
      end

      default: begin
        state_d = ST_PWRUP;
        cnt_d   = '0;
      end
    endcase

    // Opening a frame: cs_n falls now, first SCLK edge CLK_DIV cycles later.
    if (load_frame) begin
      cs_n_d  = 1'b0;
      tx_d    = load_word;
      nbits_d = load_bits;
      div_d   = '0;
      half_d  = '0;
    end

    busy_d = (state_d == ST_INIT) || (state_d == ST_READ) ||
             (state_d == ST_LATCH) || (state_d == ST_GAP);
  end

  // State and output registers; reset parks the bus idle and discards any partial read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_PWRUP;
      cnt_q          <= '0;
      div_q          <= '0;
      half_q         <= '0;
      nbits_q        <= INIT_BITS;
      tx_q           <= '0;
      rx_q           <= '0;
      init_idx_q     <= '0;
      cs_n_q         <= 1'b1;
      sclk_q         <= 1'b1;
      sdi_q          <= 1'b0;
      accel_x_q      <= '0;
      accel_y_q      <= '0;
      accel_z_q      <= '0;
      sample_valid_q <= 1'b0;
      init_done_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      div_q          <= div_d;
      half_q         <= half_d;
      nbits_q        <= nbits_d;
      tx_q           <= tx_d;
      rx_q           <= rx_d;
      init_idx_q     <= init_idx_d;
      cs_n_q         <= cs_n_d;
      sclk_q         <= sclk_d;
      sdi_q          <= sdi_d;
      accel_x_q      <= accel_x_d;
      accel_y_q      <= accel_y_d;
      accel_z_q      <= accel_z_d;
      sample_valid_q <= sample_valid_d;
      init_done_q    <= init_done_d;
      busy_q         <= busy_d;
    end
  end

  assign spi_cs_n     = cs_n_q;
  assign spi_sclk     = sclk_q;
  assign spi_sdi      = sdi_q;
  assign accel_x      = accel_x_q;
  assign accel_y      = accel_y_q;
  assign accel_z      = accel_z_q;
  assign sample_valid = sample_valid_q;
  assign init_done    = init_done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_gsensor_spi_sampler.sv
// tb_gsensor_spi_sampler: SPI slave model plus scoreboard around gsensor_spi_sampler.
// Expected frames and samples are queued as stimulus is issued and popped as the DUT produces them.
// Small parameters keep power-up and sample period short.
module tb_gsensor_spi_sampler;

  localparam int CLK_DIV       = 3;
  localparam int SAMPLE_PERIOD = 600;
  localparam int CS_GAP        = 5;
  localparam int PWRUP_WAIT    = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        gsensor_int1 = 1'b0;
  logic        spi_sdo = 1'b0;
  logic        spi_sdi, spi_sclk, spi_cs_n;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        sample_valid, init_done, busy;

  gsensor_spi_sampler #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .CS_GAP       (CS_GAP),
    .PWRUP_WAIT   (PWRUP_WAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .gsensor_int1(gsensor_int1),
    .spi_sdo     (spi_sdo),
    .spi_sdi     (spi_sdi),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .accel_x     (accel_x),
    .accel_y     (accel_y),
    .accel_z     (accel_z),
    .sample_valid(sample_valid),
    .init_done   (init_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          nbits;
    logic [63:0] mosi;
  } frame_t;

  frame_t      exp_frames[$];
  logic [47:0] exp_samples[$];
  logic [47:0] resp_q[$];
  int          read_falls[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_frame(input int nb, input logic [63:0] m);
    frame_t f;
    f.nbits = nb;
    f.mosi  = m;
    exp_frames.push_back(f);
  endtask

  task automatic push_init();
    push_frame(16, 64'h310B);
    push_frame(16, 64'h2C0A);
    push_frame(16, 64'h2D08);
  endtask

  // One read: slave response bytes X0,X1,Y0,Y1,Z0,Z1, plus the expected frame and sample.
  task automatic queue_read(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                            input bit expect_sample);
    resp_q.push_back({x[7:0], x[15:8], y[7:0], y[15:8], z[7:0], z[15:8]});
    push_frame(56, 64'h00F2_0000_0000_0000);
    if (expect_sample) exp_samples.push_back({x, y, z});
  endtask

  // SPI slave and bus monitor, observing on the falling clk edge.
  logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_valid = 1'b0;
  logic        in_frame = 1'b0;
  int          mon_bits = 0, mon_falls = 0, mon_terr = 0;
  logic [63:0] mon_rx = '0;
  logic [47:0] cur_resp = '0;
  int          last_edge = 0, fall_cyc = 0, cs_rise_cyc = 0;
  int          cs_fall_cnt = 0, n_samples = 0;
  frame_t      ef;
  logic [47:0] es;

  always @(negedge clk) begin
    if (rst) begin
      in_frame   = 1'b0;
      spi_sdo    = 1'b0;
      prev_cs    = 1'b1;
      prev_sclk  = 1'b1;
      prev_valid = 1'b0;
    end else begin
      if (prev_cs && !spi_cs_n) begin
        in_frame  = 1'b1;
        mon_bits  = 0;
        mon_falls = 0;
        mon_rx    = '0;
        mon_terr  = 0;
        last_edge = cyc;
        fall_cyc  = cyc;
        cs_fall_cnt++;
      end
      if (spi_sclk !== prev_sclk) begin
        if (!in_frame || spi_cs_n) begin
          chk("sclk_toggle_cs_high", 64'd1, 64'd0);
        end else begin
          if (cyc - last_edge != CLK_DIV) mon_terr++;
          last_edge = cyc;
          if (!spi_sclk) begin
            if (mon_falls >= 8 && mon_falls < 56) spi_sdo = cur_resp[55 - mon_falls];
            mon_falls++;
          end else begin
            mon_rx = {mon_rx[62:0], spi_sdi};
            mon_bits++;
            if (mon_bits == 8 && mon_rx[7:0] == 8'hF2)
              cur_resp = (resp_q.size() > 0) ? resp_q.pop_front() : 48'd0;
          end
        end
      end
      if (!prev_cs && spi_cs_n && in_frame) begin
        if (cyc - last_edge != CLK_DIV) mon_terr++;
        in_frame    = 1'b0;
        cs_rise_cyc = cyc;
        spi_sdo     = 1'b0;
        if (exp_frames.size() == 0) begin
          chk("frame_unexpected", 64'd1, 64'd0);
        end else begin
          ef = exp_frames.pop_front();
          chk("frame_bits", 64'(mon_bits), 64'(ef.nbits));
          chk("frame_mosi", mon_rx, ef.mosi);
        end
        chk("frame_timing", 64'(mon_terr), 64'd0);
        if (mon_bits == 56) read_falls.push_back(fall_cyc);
      end
      if (sample_valid) begin
        n_samples++;
        chk("valid_pulse_width", 64'(prev_valid), 64'd0);
        chk("valid_after_cs_rise", 64'(cyc - cs_rise_cyc), 64'd1);
        if (exp_samples.size() == 0) begin
          chk("sample_unexpected", 64'd1, 64'd0);
        end else begin
          es = exp_samples.pop_front();
          chk("accel_x", 64'(accel_x), 64'(es[47:32]));
          chk("accel_y", 64'(accel_y), 64'(es[31:16]));
          chk("accel_z", 64'(accel_z), 64'(es[15:0]));
        end
      end
      prev_valid = sample_valid;
      prev_cs    = spi_cs_n;
      prev_sclk  = spi_sclk;
    end
  end

  // Release reset and verify the power-up wait and the config sequence.
  task automatic release_and_init(input string tag);
    int c0;
    int fc;
    push_init();
    fc  = cs_fall_cnt;
    rst = 1'b0;
    c0  = cyc;
    for (int i = 0; i < PWRUP_WAIT + 100 && cs_fall_cnt == fc; i++) @(negedge clk);
    chk({tag, "_first_cs_seen"}, 64'(cs_fall_cnt > fc), 64'd1);
    chk({tag, "_pwrup_wait"}, 64'(fall_cyc - c0), 64'(PWRUP_WAIT));
    for (int i = 0; i < 2000 && !init_done; i++) @(negedge clk);
    chk({tag, "_init_done"}, 64'(init_done), 64'd1);
    chk({tag, "_init_frames_left"}, 64'(exp_frames.size()), 64'd0);
    chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int fc;
    int s0;
    logic [15:0] rx, ry, rz;

    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 64'(spi_cs_n), 64'd1);
    chk("rst_sclk", 64'(spi_sclk), 64'd1);
    chk("rst_sdi", 64'(spi_sdi), 64'd0);
    chk("rst_accel", 64'({accel_x, accel_y, accel_z}), 64'd0);
    chk("rst_valid", 64'(sample_valid), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    release_and_init("boot");

    // Three periodic reads; en dropped in the middle of the third.
    read_falls.delete();
    queue_read(16'h1234, 16'hFFFF, 16'h8000, 1'b1);
    for (int k = 0; k < 2; k++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rz = 16'($urandom);
      queue_read(rx, ry, rz, 1'b1);
    end
    s0 = n_samples;
    fc = cs_fall_cnt;
    en = 1'b1;
    for (int i = 0; i < 4 * SAMPLE_PERIOD && cs_fall_cnt < fc + 3; i++) @(negedge clk);
    repeat (40) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 2 * SAMPLE_PERIOD && n_samples < s0 + 3; i++) @(negedge clk);
    chk("read_samples", 64'(n_samples - s0), 64'd3);
    chk("read_frames_seen", 64'(read_falls.size()), 64'd3);
    if (read_falls.size() >= 3) begin
      chk("period_1", 64'(read_falls[1] - read_falls[0]), 64'(SAMPLE_PERIOD));
      chk("period_2", 64'(read_falls[2] - read_falls[1]), 64'(SAMPLE_PERIOD));
    end
    chk("last_sample_held", 64'({accel_x, accel_y, accel_z}), 64'({rx, ry, rz}));

    fc = cs_fall_cnt;
    repeat (2 * SAMPLE_PERIOD) @(negedge clk);
    chk("no_read_en_low", 64'(cs_fall_cnt), 64'(fc));
    chk("busy_en_low", 64'(busy), 64'd0);

    // Reset in the middle of a read: frame aborted, no sample, init restarts.
    queue_read(16'h5A5A, 16'hA5A5, 16'h0F0F, 1'b0);
    fc = cs_fall_cnt;
    en = 1'b1;
    for (int i = 0; i < 2 * SAMPLE_PERIOD && cs_fall_cnt == fc; i++) @(negedge clk);
    for (int i = 0; i < 500 && mon_bits < 20; i++) @(negedge clk);
    chk("midread_reached_bit20", 64'(mon_bits >= 20), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_cs_n", 64'(spi_cs_n), 64'd1);
    chk("midrst_sclk", 64'(spi_sclk), 64'd1);
    chk("midrst_valid", 64'(sample_valid), 64'd0);
    chk("midrst_init_done", 64'(init_done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_accel", 64'({accel_x, accel_y, accel_z}), 64'd0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_frame_aborted", 64'(exp_frames.size()), 64'd1);
    exp_frames.delete();
    resp_q.delete();
    release_and_init("rerun");

    // Reads resume after re-init.
    queue_read(16'h7FFF, 16'h0001, 16'hFF00, 1'b1);
    s0 = n_samples;
    en = 1'b1;
    for (int i = 0; i < 2 * SAMPLE_PERIOD && n_samples == s0; i++) @(negedge clk);
    en = 1'b0;
    chk("resume_sample", 64'(n_samples - s0), 64'd1);
    repeat (20) @(negedge clk);
    chk("samples_left", 64'(exp_samples.size()), 64'd0);
    chk("frames_left", 64'(exp_frames.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
